flight_control_mixer: RTL and testbench

//  Quadcopter flight-control core. Runs three PD controllers (pitch, roll, yaw): measured attitude vs. desired.

---
 rtl/flight_control_mixer.sv | 150 +++++++++++++++
 tb/tb_flight_control_mixer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/flight_control_mixer.sv
// ----------------------------------------------------------------------------
// flight_control_mixer
//
// Quadcopter flight-control core. Three PD controllers (pitch, roll, yaw)
// compare measured attitude against desired attitude. Their P and D terms are
// mixed with thrust into four 11-bit unsigned motor speed commands.
//
// Ports:
//   clk            in   1   system clock, rising-edge state updates
//   rst_n          in   1   asynchronous active-low reset (clears D history)
//   vld            in   1   new attitude sample; advances the D history queues
//   inertial_cal   in   1   1 = calibration, all motors forced to CAL_SPEED
//   d_ptch/d_roll/d_yaw  in 16  desired attitude, signed
//   ptch/roll/yaw        in 16  measured attitude, signed
//   thrst          in   9   thrust, unsigned
//   frnt_spd/bck_spd/lft_spd/rght_spd  out 11  motor speed commands, unsigned
//
// Outputs are combinational from the inputs and the current queue contents.
// Only the D-term history is registered.
// ----------------------------------------------------------------------------
module flight_control_mixer #(
    parameter int                 D_QUEUE_DEPTH = 12,
    parameter logic signed [4:0]  DTERM         = 5'sd7,
    parameter logic [12:0]        MIN_RUN_SPEED = 13'h2C0,
    parameter logic [10:0]        CAL_SPEED     = 11'h290
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic        inertial_cal,
    input  logic [15:0] d_ptch,
    input  logic [15:0] d_roll,
    input  logic [15:0] d_yaw,
    input  logic [15:0] ptch,
    input  logic [15:0] roll,
    input  logic [15:0] yaw,
    input  logic [8:0]  thrst,
    output logic [10:0] frnt_spd,
    output logic [10:0] bck_spd,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd
);

    // Error saturation to the 10-bit signed range.
    function automatic logic signed [9:0] sat_err(input logic signed [16:0] v);
        if (v > 17'sd511)
            return 10'sh1FF;
        else if (v < -17'sd512)
            return 10'sh200;
        else
            return v[9:0];
    endfunction

    // Derivative difference saturation to the 7-bit signed range.
    function automatic logic signed [6:0] sat_diff(input logic signed [10:0] v);
        if (v > 11'sd63)
            return 7'sh3F;
        else if (v < -11'sd64)
            return 7'sh40;
        else
            return v[6:0];
    endfunction

    // Motor command clamp: negative -> 0, above 11-bit range -> full scale.
    function automatic logic [10:0] sat_spd(input logic signed [12:0] s);
        if (s < 13'sd0)
            return 11'h000;
        else if (s > 13'sd2047)
            return 11'h7FF;
        else
            return s[10:0];
    endfunction

    // Axis index: 0 = pitch, 1 = roll, 2 = yaw.
    logic [15:0]        act [3];
    logic [15:0]        des [3];
    logic signed [12:0] p13 [3];
    logic signed [12:0] d13 [3];

    assign act[0] = ptch;
    assign act[1] = roll;
    assign act[2] = yaw;
    assign des[0] = d_ptch;
    assign des[1] = d_roll;
    assign des[2] = d_yaw;

    for (genvar a = 0; a < 3; a++) begin : g_axis
        logic signed [16:0] err;
        logic signed [9:0]  err_sat;
        logic signed [9:0]  p_term;
        logic signed [10:0] d_diff;
        logic signed [6:0]  d_diff_sat;
        logic signed [11:0] d_term;
        logic signed [9:0]  hist_q [D_QUEUE_DEPTH];
        logic signed [9:0]  hist_d [D_QUEUE_DEPTH];

        // Sign-extend both operands by one bit so the difference cannot wrap.
        assign err     = {act[a][15], act[a]} - {des[a][15], des[a]};
        assign err_sat = sat_err(err);

        // 5/8 proportional gain from two arithmetic shifts.
        assign p_term = (err_sat >>> 1) + (err_sat >>> 3);

        // Entry 0 is the newest sample, the last entry is the oldest.
        always_comb begin
            hist_d[0] = err_sat;
            for (int i = 1; i < D_QUEUE_DEPTH; i++)
                hist_d[i] = hist_q[i-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < D_QUEUE_DEPTH; i++)
                    hist_q[i] <= '0;
            end else if (vld) begin
                for (int i = 0; i < D_QUEUE_DEPTH; i++)
                    hist_q[i] <= hist_d[i];
            end
        end

        assign d_diff     = {err_sat[9], err_sat}
                          - {hist_q[D_QUEUE_DEPTH-1][9], hist_q[D_QUEUE_DEPTH-1]};
        assign d_diff_sat = sat_diff(d_diff);

        // Both factors sign-extended to 12 bits; the low 12 product bits are
        // the exact signed result since |7b * 5b| fits in 12 bits.
        assign d_term = {{5{d_diff_sat[6]}}, d_diff_sat} * {{7{DTERM[4]}}, DTERM};

        assign p13[a] = {{3{p_term[9]}}, p_term};
        assign d13[a] = {d_term[11], d_term};
    end

    logic signed [12:0] base;
    logic signed [12:0] frnt_sum;
    logic signed [12:0] bck_sum;
    logic signed [12:0] lft_sum;
    logic signed [12:0] rght_sum;

    assign base     = MIN_RUN_SPEED + {4'b0000, thrst};
    assign frnt_sum = base - p13[0] - d13[0] - p13[2] - d13[2];
    assign bck_sum  = base + p13[0] + d13[0] - p13[2] - d13[2];
    assign lft_sum  = base - p13[1] - d13[1] + p13[2] + d13[2];
    assign rght_sum = base + p13[1] + d13[1] + p13[2] + d13[2];

    assign frnt_spd = inertial_cal ? CAL_SPEED : sat_spd(frnt_sum);
    assign bck_spd  = inertial_cal ? CAL_SPEED : sat_spd(bck_sum);
    assign lft_spd  = inertial_cal ? CAL_SPEED : sat_spd(lft_sum);
    assign rght_spd = inertial_cal ? CAL_SPEED : sat_spd(rght_sum);

endmodule

// File: tb/tb_flight_control_mixer.sv
// Self-checking bench for flight_control_mixer: constant vector table,
// hand-written multi-cycle sequences, and randomized traffic against a
// behavioural model built from the controller/mixer rules.
module tb_flight_control_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic        inertial_cal;
    logic [15:0] d_ptch, d_roll, d_yaw, ptch, roll, yaw;
    logic [8:0]  thrst;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;

    int checks   = 0;
    int failures = 0;

    // Model history: hq[axis][0] newest, hq[axis][11] oldest.
    int hq [3][12];

    always #5 clk = ~clk;

    flight_control_mixer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld         (vld),
        .inertial_cal(inertial_cal),
        .d_ptch      (d_ptch),
        .d_roll      (d_roll),
        .d_yaw       (d_yaw),
        .ptch        (ptch),
        .roll        (roll),
        .yaw         (yaw),
        .thrst       (thrst),
        .frnt_spd    (frnt_spd),
        .bck_spd     (bck_spd),
        .lft_spd     (lft_spd),
        .rght_spd    (rght_spd)
    );

    typedef struct {
        logic        cal;
        logic [8:0]  thr;
        logic [15:0] p, r, y, dp, dr, dy;
        logic [10:0] ef, eb, el, er;
    } vec_t;

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input logic [10:0] ef, input logic [10:0] eb,
                        input logic [10:0] el, input logic [10:0] er);
        chk({nm, ".frnt"}, frnt_spd, ef);
        chk({nm, ".bck"},  bck_spd,  eb);
        chk({nm, ".lft"},  lft_spd,  el);
        chk({nm, ".rght"}, rght_spd, er);
    endtask

    task automatic set_in(input logic cal, input logic [8:0] thr,
                          input logic [15:0] p, input logic [15:0] r, input logic [15:0] y,
                          input logic [15:0] dp, input logic [15:0] dr, input logic [15:0] dy);
        inertial_cal = cal; thrst = thr;
        ptch = p; roll = r; yaw = y;
        d_ptch = dp; d_roll = dr; d_yaw = dy;
    endtask

    // One vld clock: raise vld away from the edge, let the edge pass, drop it.
    task automatic pulse_vld();
        @(negedge clk);
        vld = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0;
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int err_sat(input logic [15:0] a, input logic [15:0] d);
        return clamp(int'($signed(a)) - int'($signed(d)), -512, 511);
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 3; a++)
            for (int i = 0; i < 12; i++)
                hq[a][i] = 0;
    endtask

    task automatic model_push();
        int e [3];
        e[0] = err_sat(ptch, d_ptch);
        e[1] = err_sat(roll, d_roll);
        e[2] = err_sat(yaw, d_yaw);
        for (int a = 0; a < 3; a++) begin
            for (int i = 11; i > 0; i--)
                hq[a][i] = hq[a][i-1];
            hq[a][0] = e[a];
        end
    endtask

    task automatic model_out(output logic [10:0] f, output logic [10:0] b,
                             output logic [10:0] l, output logic [10:0] r);
        int e [3];
        int t [3];
        int base;
        e[0] = err_sat(ptch, d_ptch);
        e[1] = err_sat(roll, d_roll);
        e[2] = err_sat(yaw, d_yaw);
        // Axis contribution = 5/8 P term (floor-shifted) + 7x clamped difference.
        for (int a = 0; a < 3; a++)
            t[a] = (e[a] >>> 1) + (e[a] >>> 3) + 7 * clamp(e[a] - hq[a][11], -64, 63);
        base = 704 + int'(thrst);
        if (inertial_cal) begin
            f = 11'h290; b = 11'h290; l = 11'h290; r = 11'h290;
        end else begin
            f = 11'(clamp(base - t[0] - t[2], 0, 2047));
            b = 11'(clamp(base + t[0] - t[2], 0, 2047));
            l = 11'(clamp(base - t[1] + t[2], 0, 2047));
            r = 11'(clamp(base + t[1] + t[2], 0, 2047));
        end
    endtask

    function automatic logic [15:0] rnd16();
        logic [15:0] v;
        if ($urandom_range(0, 3) == 0)
            v = 16'($urandom);
        else
            v = 16'($urandom_range(0, 1400)) - 16'd700;
        return v;
    endfunction

    vec_t tbl [8];

    initial begin
        logic [10:0] mf, mb, ml, mr;

        tbl[0] = '{1'b0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                   11'h2C0, 11'h2C0, 11'h2C0, 11'h2C0};
        tbl[1] = '{1'b0, 9'h040, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                   11'h300, 11'h300, 11'h300, 11'h300};
        tbl[2] = '{1'b1, 9'h1A5, 16'h1234, 16'hF00D, 16'h7FFF, 16'h0042, 16'h8000, 16'h0100,
                   11'h290, 11'h290, 11'h290, 11'h290};
        tbl[3] = '{1'b0, 9'h000, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                   11'h246, 11'h33A, 11'h2C0, 11'h2C0};
        // Desired side negates the error: mirror of entry 3.
        tbl[4] = '{1'b0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000,
                   11'h33A, 11'h246, 11'h2C0, 11'h2C0};
        // 704+511 -/+ 759 yaw, -/+ 759 roll.
        tbl[5] = '{1'b0, 9'h1FF, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000,
                   11'h1C8, 11'h1C8, 11'h4BF, 11'h7FF};
        // Pitch and yaw each contribute -768: frnt 2240, bck 704, lft/rght -64.
        tbl[6] = '{1'b0, 9'h000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000,
                   11'h7FF, 11'h2C0, 11'h000, 11'h000};
        // Roll error +4: P=2, D=28 -> lft 674, rght 734.
        tbl[7] = '{1'b0, 9'h000, 16'h0000, 16'h0007, 16'h0000, 16'h0000, 16'h0003, 16'h0000,
                   11'h2C0, 11'h2C0, 11'h2A2, 11'h2DE};

        // Reset state.
        rst_n = 1'b0; vld = 1'b0;
        set_in(1'b0, 9'h000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        #12;
        chk4("reset_zero", 11'h2C0, 11'h2C0, 11'h2C0, 11'h2C0);
        thrst = 9'h040;
        #1;
        chk4("reset_thrst", 11'h300, 11'h300, 11'h300, 11'h300);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: history stays zero because vld is never raised here.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_in(tbl[k].cal, tbl[k].thr, tbl[k].p, tbl[k].r, tbl[k].y,
                   tbl[k].dp, tbl[k].dr, tbl[k].dy);
            #2;
            chk4($sformatf("vec%0d", k), tbl[k].ef, tbl[k].eb, tbl[k].el, tbl[k].er);
        end

        // History fill: D term vanishes only once the 12th sample lands.
        set_in(1'b0, 9'h000, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int k = 1; k <= 12; k++) begin
            pulse_vld();
            if (k == 11) chk4("dq_11", 11'h246, 11'h33A, 11'h2C0, 11'h2C0);
        end
        chk4("dq_12", 11'h2B6, 11'h2CA, 11'h2C0, 11'h2C0);
        repeat (3) @(posedge clk);
        #1;
        chk4("dq_hold", 11'h2B6, 11'h2CA, 11'h2C0, 11'h2C0);
        // Error back to 0 against a history of 16: D=-112.
        ptch = 16'h0000;
        #1;
        chk4("dq_fall", 11'h330, 11'h250, 11'h2C0, 11'h2C0);

        // Async reset away from any edge wipes history at once.
        ptch = 16'h0010;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk4("async_rst", 11'h246, 11'h33A, 11'h2C0, 11'h2C0);
        @(negedge clk);
        rst_n = 1'b1;

        // Calibration overrides, while history keeps advancing underneath.
        inertial_cal = 1'b1;
        for (int k = 0; k < 12; k++) pulse_vld();
        chk4("cal_on", 11'h290, 11'h290, 11'h290, 11'h290);
        inertial_cal = 1'b0;
        #1;
        chk4("cal_off", 11'h2B6, 11'h2CA, 11'h2C0, 11'h2C0);

        // Randomized traffic against the model.
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 7) == 0, 9'($urandom), rnd16(), rnd16(), rnd16(),
                   rnd16(), rnd16(), rnd16());
            vld = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            model_out(mf, mb, ml, mr);
            chk4($sformatf("rnd%0d", i), mf, mb, ml, mr);
            @(posedge clk);
            if (vld) model_push();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
